cons: RTL and testbench
=======================

Name: cons

Overview:
- Receive-side consumer for the unhandshaked val/data stream emitted by the team's prod block.
- A burst is a run of consecutive cycles with val=1; a gap is a run with val=0.
- The block frames each burst, computes per-burst length, sum and maximum, and checks the link protocol (burst length, data range, gap length).
- It sits directly at the prod output in block-level benches and in the datapath.

Parameters:
- DW, 8, data width.
- LW, 4, burst-length and gap-counter width; both counters saturate at 2^LW-1.
- SW, 12, burst-sum width; sum saturates at 2^SW-1.
- MIN_BURST, 3, minimum legal burst length.
- MAX_BURST, 5, maximum legal burst length.
- MAX_DATA, 5, maximum legal data value.
- MAX_GAP, 4, maximum legal gap length between bursts.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- val  input  1  data valid from producer; no backpressure.
- data  input  DW  sampled only when val=1; the value is ignored (may be X/Z) when val=0.
- done  output  1  one-cycle pulse; summary outputs are valid this cycle.
- burst_len  output  LW  length of the last completed burst.
- burst_sum  output  SW  sum of the data words in the last burst.
- burst_max  output  DW  largest data word in the last burst.
- err_len  output  1  last burst length was < MIN_BURST or > MAX_BURST.
- err_data  output  1  some word in the last burst was > MAX_DATA.
- err_gap  output  1  gap preceding the last burst was > MAX_GAP.
- burst_cnt  output  16  completed bursts since reset; wraps modulo 2^16.
- err_any  output  1  sticky OR of all err_* pulses since reset.

Behaviour:
- **Reset.** When rst_b=0 at a rising edge, all outputs clear to 0, the FSM goes to IDLE, accumulators and gap counter clear, and the first-burst flag is set.
  - Reset mid-burst discards the partial burst; no done is produced for it.
- **FSM states.** Two states, IDLE and RECV; every decision is made on the value of val sampled at the edge.
- **IDLE, val=1.**
  - Go to RECV.
  - Load: acc_len=1, acc_sum=data, acc_max=data, acc_derr=(data>MAX_DATA).
  - Latch gap_bad=(gap_cnt>MAX_GAP) && !first, then clear first.
- **IDLE, val=0.** gap_cnt increments, saturating at 2^LW-1.
- **RECV, val=1.**
  - acc_len+1 (saturating); acc_sum+data (zero-extended, saturating); acc_max=max(acc_max, data); acc_derr |= (data>MAX_DATA).
- **RECV, val=0.** The burst ends; on this same edge:
  - done<=1.
  - burst_len/sum/max<=acc_len/acc_sum/acc_max.
  - err_len<=(acc_len<MIN_BURST || acc_len>MAX_BURST); err_data<=acc_derr; err_gap<=gap_bad.
  - burst_cnt+1; err_any |= the new err_* values.
  - gap_cnt<=1 (this val=0 cycle counts as the first gap cycle); FSM -> IDLE.
- **done timing.** done is high in the single cycle following the first val=0 sample after a burst, and low in all other cycles.
- **Output hold.** Summary and err_* outputs hold their values until the next done. They are not cleared when done drops.
- **Latency.** The summary appears one cycle after the last data word has been sampled, plus the one val=0 cycle that terminates the burst.
- **Gap check on first burst.** The first burst after reset has no gap check (err_gap=0), however long val stayed low after reset.
- **Back-to-back bursts.** A gap of exactly 1 cycle is legal. The done of one burst and the start of the next can coincide in the same cycle; the new burst's accumulators load independently of the summary registers.
- **Unterminated burst.** A burst still active at the end of simulation never reports.
- **Saturation.** burst_len reads 15 for any burst of ≥15 words, and err_len is set.

Test Plan:
- Reset held 2 cycles, then val=1 for 4 cycles with data 1,5,0,3, then val=0 -> one done pulse 1 cycle after the first val=0; len=4, sum=9, max=5, all err=0, burst_cnt=1.
- Bursts of 3 then 5 words separated by a 1-cycle gap, then a 2-word burst after a 4-cycle gap:
  - -> three done pulses; err_len=0,0,1; err_gap=0 on all; burst_cnt=3; err_any=1 from the third done onward.
- Burst with data 2,7,1 -> err_data=1, max=7, sum=10; a following clean burst -> err_data=0 while err_any stays 1.
- 3-word burst, 6-cycle gap, 3-word burst -> second done has err_gap=1.
  - A first burst starting 10 cycles after reset has err_gap=0.
- rst_b=0 for one cycle after 2 words of a burst -> no done, burst_cnt=0, all outputs 0.
  - A subsequent 3-word burst reports len=3 with no gap error.
- 20-word burst of 0xFF -> len=15, sum=4095 (saturated), max=255, err_len=1, err_data=1.
  - Drive the prod block into cons for 100 cycles -> err_any=0 and burst_cnt equals the number of val rising edges that were followed by a terminating val=0 before the end of simulation.

Source files
------------

// File: rtl/cons.sv
// cons: receive-side consumer for the prod val/data stream.
// Frames each burst (run of val=1), accumulates length/sum/max, and
// reports one done pulse per terminated burst together with protocol
// error flags (burst length, data range, preceding gap length).
module cons #(
  parameter int DW        = 8,
  parameter int LW        = 4,
  parameter int SW        = 12,
  parameter int MIN_BURST = 3,
  parameter int MAX_BURST = 5,
  parameter int MAX_DATA  = 5,
  parameter int MAX_GAP   = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          val,
  input  logic [DW-1:0] data,
  output logic          done,
  output logic [LW-1:0] burst_len,
  output logic [SW-1:0] burst_sum,
  output logic [DW-1:0] burst_max,
  output logic          err_len,
  output logic          err_data,
  output logic          err_gap,
  output logic [15:0]   burst_cnt,
  output logic          err_any
);

  typedef enum logic {IDLE, RECV} state_t;

  // Summary record latched on each burst termination.
  typedef struct packed {
    logic [LW-1:0] len;
    logic [SW-1:0] sum;
    logic [DW-1:0] max;
    logic          e_len;
    logic          e_data;
    logic          e_gap;
  } summ_t;

  localparam logic [LW-1:0] LEN_SAT   = '1;
  localparam logic [SW-1:0] SUM_SAT   = '1;
  localparam logic [LW-1:0] MIN_LEN_W = LW'(MIN_BURST);
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_BURST);
  localparam logic [LW-1:0] MAX_GAP_W = LW'(MAX_GAP);
  localparam logic [DW-1:0] MAX_DAT_W = DW'(MAX_DATA);

  state_t        state_q, state_d;
  logic [LW-1:0] acc_len_q, acc_len_d;
  logic [SW-1:0] acc_sum_q, acc_sum_d;
  logic [DW-1:0] acc_max_q, acc_max_d;
  logic          acc_derr_q, acc_derr_d;
  logic [LW-1:0] gap_cnt_q, gap_cnt_d;
  logic          gap_bad_q, gap_bad_d;
  logic          first_q, first_d;
  logic          done_q, done_d;
  summ_t         summ_q, summ_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;
  logic          err_any_q, err_any_d;

  // Datapath helpers; data is only meaningful when val=1.
  logic          data_big;
  logic [LW-1:0] len_inc;
  logic [LW-1:0] gap_inc;
  logic [SW:0]   sum_ext;
  logic [SW-1:0] sum_inc;
  logic [DW-1:0] max_upd;
  logic          len_bad;

  // Saturating increments, sum and running max for the accumulators.
  always_comb begin
    data_big = val && (data > MAX_DAT_W);
    len_inc  = (acc_len_q == LEN_SAT) ? LEN_SAT : acc_len_q + LW'(1);
    gap_inc  = (gap_cnt_q == LEN_SAT) ? LEN_SAT : gap_cnt_q + LW'(1);
    sum_ext  = {1'b0, acc_sum_q} + {{(SW+1-DW){1'b0}}, data};
    sum_inc  = sum_ext[SW] ? SUM_SAT : sum_ext[SW-1:0];
    max_upd  = (data > acc_max_q) ? data : acc_max_q;
    len_bad  = (acc_len_q < MIN_LEN_W) || (acc_len_q > MAX_LEN_W);
  end

  // Next-state and register-update logic for the two-state framer.
  always_comb begin
    state_d     = state_q;
    acc_len_d   = acc_len_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    acc_derr_d  = acc_derr_q;
    gap_cnt_d   = gap_cnt_q;
    gap_bad_d   = gap_bad_q;
    first_d     = first_q;
    done_d      = 1'b0;
    summ_d      = summ_q;
    burst_cnt_d = burst_cnt_q;
    err_any_d   = err_any_q;
    unique case (state_q)
      IDLE: begin
        if (val) begin
          state_d    = RECV;
          acc_len_d  = LW'(1);
          acc_sum_d  = {{(SW-DW){1'b0}}, data};
          acc_max_d  = data;
          acc_derr_d = data_big;
          // First burst after reset has no meaningful preceding gap.
          gap_bad_d  = (gap_cnt_q > MAX_GAP_W) && !first_q;
          first_d    = 1'b0;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end
      RECV: begin
        if (val) begin
          acc_len_d  = len_inc;
          acc_sum_d  = sum_inc;
          acc_max_d  = max_upd;
          acc_derr_d = acc_derr_q | data_big;
        end else begin
          state_d       = IDLE;
          done_d        = 1'b1;
          summ_d.len    = acc_len_q;
          summ_d.sum    = acc_sum_q;
          summ_d.max    = acc_max_q;
          summ_d.e_len  = len_bad;
          summ_d.e_data = acc_derr_q;
          summ_d.e_gap  = gap_bad_q;
          burst_cnt_d   = burst_cnt_q + 16'd1;
          err_any_d     = err_any_q | len_bad | acc_derr_q | gap_bad_q;
          // The terminating val=0 cycle is the first cycle of the gap.
          gap_cnt_d     = LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      acc_len_q   <= '0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_derr_q  <= 1'b0;
      gap_cnt_q   <= '0;
      gap_bad_q   <= 1'b0;
      first_q     <= 1'b1;
      done_q      <= 1'b0;
      summ_q      <= '0;
      burst_cnt_q <= '0;
      err_any_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_len_q   <= acc_len_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_derr_q  <= acc_derr_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_bad_q   <= gap_bad_d;
      first_q     <= first_d;
      done_q      <= done_d;
      summ_q      <= summ_d;
      burst_cnt_q <= burst_cnt_d;
      err_any_q   <= err_any_d;
    end
  end

  assign done      = done_q;
  assign burst_len = summ_q.len;
  assign burst_sum = summ_q.sum;
  assign burst_max = summ_q.max;
  assign err_len   = summ_q.e_len;
  assign err_data  = summ_q.e_data;
  assign err_gap   = summ_q.e_gap;
  assign burst_cnt = burst_cnt_q;
  assign err_any   = err_any_q;

endmodule

// File: tb/tb_cons.sv
// Bench for cons: a behavioural model pushes an expected summary record
// (with the cycle its done must appear) when a burst terminates; a negedge
// monitor pops and compares. Scenario tasks add fixed-value checks.
module tb_cons;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        val;
  logic [7:0]  data;
  logic        done;
  logic [3:0]  burst_len;
  logic [11:0] burst_sum;
  logic [7:0]  burst_max;
  logic        err_len, err_data, err_gap;
  logic [15:0] burst_cnt;
  logic        err_any;

  cons dut (
    .clk(clk), .rst_b(rst_b), .val(val), .data(data), .done(done),
    .burst_len(burst_len), .burst_sum(burst_sum), .burst_max(burst_max),
    .err_len(err_len), .err_data(err_data), .err_gap(err_gap),
    .burst_cnt(burst_cnt), .err_any(err_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len, sum, max;
    bit el, ed, eg;
    int cnt;
    bit any;
    int stamp;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Behavioural model state
  bit m_recv, m_first, m_derr, m_gbad, m_any;
  int m_len, m_sum, m_max, m_gap, m_cnt;

  // Advance one clock with the given inputs, then update the model.
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    rst_b = r;
    val   = v;
    data  = v ? d : 8'hxx;
    @(posedge clk);
    cyc_n++;
    if (!r) begin
      m_recv = 0; m_first = 1; m_derr = 0; m_gbad = 0; m_any = 0;
      m_len = 0; m_sum = 0; m_max = 0; m_gap = 0; m_cnt = 0;
    end else if (!m_recv) begin
      if (v) begin
        m_recv = 1; m_len = 1; m_sum = d; m_max = d; m_derr = (d > 5);
        m_gbad = (m_gap > 4) && !m_first; m_first = 0;
      end else if (m_gap < 15) m_gap++;
    end else if (v) begin
      if (m_len < 15) m_len++;
      m_sum = (m_sum + d > 4095) ? 4095 : m_sum + d;
      if (d > m_max) m_max = d;
      if (d > 5) m_derr = 1;
    end else begin
      exp_t e;
      e.len = m_len; e.sum = m_sum; e.max = m_max;
      e.el = (m_len < 3) || (m_len > 5); e.ed = m_derr; e.eg = m_gbad;
      m_cnt = (m_cnt + 1) % 65536;
      m_any = m_any | e.el | e.ed | e.eg;
      e.cnt = m_cnt; e.any = m_any; e.stamp = cyc_n;
      q.push_back(e);
      m_gap = 1; m_recv = 0;
    end
    #1;
  endtask

  // Scoreboard consumer: done must appear exactly in the predicted cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].stamp == cyc_n) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (done !== 1'b1 || burst_len !== 4'(e.len) || burst_sum !== 12'(e.sum) ||
          burst_max !== 8'(e.max) || err_len !== e.el || err_data !== e.ed ||
          err_gap !== e.eg || burst_cnt !== 16'(e.cnt) || err_any !== e.any)
      begin
        n_bad++;
        $display("FAIL sb_done cyc=%0d got done=%b len=%0d sum=%0d max=%0d el=%b ed=%b eg=%b cnt=%0d any=%b exp len=%0d sum=%0d max=%0d el=%b ed=%b eg=%b cnt=%0d any=%b",
                 cyc_n, done, burst_len, burst_sum, burst_max, err_len, err_data, err_gap,
                 burst_cnt, err_any, e.len, e.sum, e.max, e.el, e.ed, e.eg, e.cnt, e.any);
      end
    end else if (q.size() > 0 && q[0].stamp < cyc_n) begin
      void'(q.pop_front());
      n_cmp++; n_bad++;
      $display("FAIL sb_missing cyc=%0d done never seen (expected 1)", cyc_n);
    end else if (cyc_n > 0) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_spurious cyc=%0d done=%b expected 0", cyc_n, done);
      end
    end
  end

  task automatic do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({done, burst_len, burst_sum, burst_max, err_len, err_data, err_gap,
         burst_cnt, err_any} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got done=%b len=%0d sum=%0d max=%0d cnt=%0d any=%b expected all 0",
               done, burst_len, burst_sum, burst_max, burst_cnt, err_any);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v [4];
    v = '{8'd1, 8'd5, 8'd0, 8'd3};
    do_reset();
    foreach (v[i]) step(1, 1, v[i]);
    step(1, 0, 0);
    n_cmp++;
    if (done !== 1 || burst_len !== 4 || burst_sum !== 9 || burst_max !== 5 ||
        {err_len, err_data, err_gap, err_any} !== 0 || burst_cnt !== 1) begin
      n_bad++;
      $display("FAIL basic got done=%b len=%0d sum=%0d max=%0d errs=%b%b%b%b cnt=%0d expected 1/4/9/5/0000/1",
               done, burst_len, burst_sum, burst_max, err_len, err_data, err_gap, err_any, burst_cnt);
    end
    step(1, 0, 0);
    n_cmp++;
    if (done !== 0 || burst_len !== 4 || burst_sum !== 9) begin
      n_bad++;
      $display("FAIL basic_hold got done=%b len=%0d sum=%0d expected 0/4/9", done, burst_len, burst_sum);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 8'd1);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 8'd2);
    n_cmp++;
    if (burst_len !== 3 || err_any !== 0) begin
      n_bad++;
      $display("FAIL b2b_first got len=%0d any=%b expected 3/0", burst_len, err_any);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    n_cmp++;
    if (burst_len !== 5 || burst_sum !== 10 || err_len !== 0 || err_gap !== 0 || err_any !== 0) begin
      n_bad++;
      $display("FAIL b2b_second got len=%0d sum=%0d el=%b eg=%b any=%b expected 5/10/0/0/0",
               burst_len, burst_sum, err_len, err_gap, err_any);
    end
    step(1, 1, 8'd4);
    step(1, 1, 8'd4);
    step(1, 0, 0);
    n_cmp++;
    if (burst_len !== 2 || err_len !== 1 || err_gap !== 0 || burst_cnt !== 3 || err_any !== 1) begin
      n_bad++;
      $display("FAIL b2b_third got len=%0d el=%b eg=%b cnt=%0d any=%b expected 2/1/0/3/1",
               burst_len, err_len, err_gap, burst_cnt, err_any);
    end
    step(1, 0, 0);
  endtask

  task automatic test_data_err();
    logic [7:0] v [3];
    v = '{8'd2, 8'd7, 8'd1};
    do_reset();
    foreach (v[i]) step(1, 1, v[i]);
    step(1, 0, 0);
    n_cmp++;
    if (err_data !== 1 || burst_max !== 7 || burst_sum !== 10 || err_any !== 1) begin
      n_bad++;
      $display("FAIL data_err got ed=%b max=%0d sum=%0d any=%b expected 1/7/10/1",
               err_data, burst_max, burst_sum, err_any);
    end
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'd5);
    step(1, 0, 0);
    n_cmp++;
    if (err_data !== 0 || burst_max !== 5 || err_any !== 1) begin
      n_bad++;
      $display("FAIL data_clean got ed=%b max=%0d any=%b expected 0/5/1", err_data, burst_max, err_any);
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'd3);
    step(1, 0, 0);
    n_cmp++;
    if (err_gap !== 0) begin
      n_bad++;
      $display("FAIL gap_first got eg=%b expected 0", err_gap);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'd3);
    step(1, 0, 0);
    n_cmp++;
    if (err_gap !== 1 || err_len !== 0 || err_any !== 1 || burst_cnt !== 2) begin
      n_bad++;
      $display("FAIL gap_long got eg=%b el=%b any=%b cnt=%0d expected 1/0/1/2",
               err_gap, err_len, err_any, burst_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1, 1, 8'd1);
    step(1, 1, 8'd2);
    step(0, 1, 8'd3);
    step(1, 0, 0);
    n_cmp++;
    if ({done, burst_len, burst_sum, burst_max, err_len, err_data, err_gap,
         burst_cnt, err_any} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got done=%b len=%0d sum=%0d cnt=%0d expected all 0",
               done, burst_len, burst_sum, burst_cnt);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 8'd2);
    step(1, 0, 0);
    n_cmp++;
    if (burst_len !== 3 || burst_sum !== 6 || err_gap !== 0 || burst_cnt !== 1) begin
      n_bad++;
      $display("FAIL mid_reset_after got len=%0d sum=%0d eg=%b cnt=%0d expected 3/6/0/1",
               burst_len, burst_sum, err_gap, burst_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 8'hFF);
    step(1, 0, 0);
    n_cmp++;
    if (burst_len !== 15 || burst_sum !== 4095 || burst_max !== 255 ||
        err_len !== 1 || err_data !== 1) begin
      n_bad++;
      $display("FAIL saturation got len=%0d sum=%0d max=%0d el=%b ed=%b expected 15/4095/255/1/1",
               burst_len, burst_sum, burst_max, err_len, err_data);
    end
  endtask

  // Legal producer-like traffic for ~100 cycles.
  task automatic test_random();
    int nb, start;
    nb = 0;
    do_reset();
    start = cyc_n;
    while (cyc_n - start < 100) begin
      int bl, gl;
      bl = $urandom_range(3, 5);
      gl = $urandom_range(1, 4);
      for (int i = 0; i < bl; i++) step(1, 1, 8'($urandom_range(0, 5)));
      for (int i = 0; i < gl; i++) step(1, 0, 0);
      nb++;
    end
    n_cmp++;
    if (err_any !== 0 || burst_cnt !== 16'(nb)) begin
      n_bad++;
      $display("FAIL random got any=%b cnt=%0d expected 0/%0d", err_any, burst_cnt, nb);
    end
  endtask

  initial begin
    rst_b = 0; val = 0; data = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_data_err();
    test_gap();
    test_mid_reset();
    test_saturation();
    test_random();
    step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
